// File: rtl/scoreboard_stall_unit_if.sv
// ---------------------------------------------------------------------------
// scoreboard_stall_unit_if
// Bundles the ID-stage signals that the scoreboard tracker listens to and the
// hazard indications it returns.
//   master : ID-stage side. Drives the instruction fields and flush.
//            Receives stall, busy_rs1, busy_rs2 and pending_count.
//   slave  : scoreboard side. The directions are the reverse of master.
// ---------------------------------------------------------------------------
interface scoreboard_stall_unit_if #(
  parameter int REG_W = 5,
  parameter int LAT_W = 3
) ();
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic [LAT_W-1:0] id_latency;
  logic             flush;
  logic             stall;
  logic             busy_rs1;
  logic             busy_rs2;
  logic [REG_W:0]   pending_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_latency, flush,
    input  stall, busy_rs1, busy_rs2, pending_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_latency, flush,
    output stall, busy_rs1, busy_rs2, pending_count
  );
endinterface

// File: rtl/scoreboard_stall_unit.sv
// ---------------------------------------------------------------------------
// scoreboard_stall_unit
// Producer-side hazard tracker for the ID stage. Each architectural register
// has a down-counter holding the number of cycles left before its in-flight
// result becomes forwardable. The instruction in ID is stalled while any
// register it reads or writes is still counting down. Once a counter reaches
// zero, the bypass network covers the dependency.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   sb    : slave side of scoreboard_stall_unit_if, which carries:
//           - ID instruction fields: id_valid, id_rs1/2, id_use_rs1/2,
//             id_rd, id_regwrite and id_latency
//           - flush
//           - outputs: stall, busy_rs1/2 and pending_count (registered)
// ---------------------------------------------------------------------------
module scoreboard_stall_unit #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int LAT_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  scoreboard_stall_unit_if.slave sb
);

  localparam logic [REG_W-1:0] IDX_ZERO = {REG_W{1'b0}};
  localparam logic [LAT_W-1:0] CNT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] CNT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_W:0]   POP_ZERO = {(REG_W+1){1'b0}};
  localparam logic [REG_W:0]   POP_ONE  = {{REG_W{1'b0}}, 1'b1};

  typedef logic [LAT_W-1:0] cnt_arr_t [NUM_REGS];

  cnt_arr_t         cnt_q;
  cnt_arr_t         cnt_d;
  logic [REG_W:0]   pending_count_q;
  logic [REG_W:0]   pending_count_d;

  logic             busy_rs1_s;
  logic             busy_rs2_s;
  logic             waw_s;
  logic             stall_s;
  logic             issue_s;

  // Number of registers whose countdown is still nonzero.
  function automatic logic [REG_W:0] count_pending(input cnt_arr_t c);
    logic [REG_W:0] n;
    n = POP_ZERO;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (c[r] != CNT_ZERO) begin
        n = n + POP_ONE;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Hazard detection and issue qualification. The counter for x0 is always
  // zero, so x0 can never appear busy. The explicit index test makes that
  // guarantee independent of the counter state.
  always_comb begin
    busy_rs1_s = sb.id_use_rs1 && (sb.id_rs1 != IDX_ZERO) &&
                 (cnt_q[sb.id_rs1] != CNT_ZERO);
    busy_rs2_s = sb.id_use_rs2 && (sb.id_rs2 != IDX_ZERO) &&
                 (cnt_q[sb.id_rs2] != CNT_ZERO);
    // A younger write must not overtake an older long-latency write to the
    // same register.
    waw_s      = sb.id_regwrite && (sb.id_rd != IDX_ZERO) &&
                 (cnt_q[sb.id_rd] != CNT_ZERO);
    stall_s    = sb.id_valid && !sb.flush && (busy_rs1_s || busy_rs2_s || waw_s);
    // Latency 0 means a single-cycle ALU result that relies only on bypass.
    issue_s    = sb.id_valid && !stall_s && !sb.flush && sb.id_regwrite &&
                 (sb.id_rd != IDX_ZERO) && (sb.id_latency != CNT_ZERO);
  end

  // Next value of each counter, in priority order: flush, issue, decrement.
  // Issue never targets a nonzero counter because waw stalls that case.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = CNT_ZERO;
      end else if (sb.flush) begin
        cnt_d[r] = CNT_ZERO;
      end else if (issue_s && (sb.id_rd == REG_W'(r))) begin
        cnt_d[r] = sb.id_latency;
      end else if (cnt_q[r] != CNT_ZERO) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // pending_count is computed from the next counter state, so that once
  // registered it matches the counters in the same cycle.
  always_comb begin
    pending_count_d = count_pending(cnt_d);
  end

  // Counter and pending-count registers. Reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      pending_count_q <= POP_ZERO;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      pending_count_q <= pending_count_d;
    end
  end

  assign sb.stall         = stall_s;
  assign sb.busy_rs1      = busy_rs1_s;
  assign sb.busy_rs2      = busy_rs2_s;
  assign sb.pending_count = pending_count_q;

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_scoreboard_stall_unit
// Directed bench for scoreboard_stall_unit. Inputs change on the falling edge.
// Outputs are sampled 1 time unit later, so each check sees the counter state
// registered at the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_scoreboard_stall_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  scoreboard_stall_unit_if #(.REG_W(5), .LAT_W(3)) sb_if ();

  scoreboard_stall_unit #(
    .NUM_REGS(32),
    .REG_W   (5),
    .LAT_W   (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic [2:0] lat, input logic fl);
    sb_if.id_valid    = v;
    sb_if.id_rs1      = rs1;
    sb_if.id_use_rs1  = u1;
    sb_if.id_rs2      = rs2;
    sb_if.id_use_rs2  = u2;
    sb_if.id_rd       = rd;
    sb_if.id_regwrite = rw;
    sb_if.id_latency  = lat;
    sb_if.flush       = fl;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, lat, 1'b0);
  endtask

  task automatic reader(input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    drive(1'b1, rs1, u1, rs2, u2, 5'd0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held with arbitrary, hazard-looking inputs.
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 3'd7, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_stall", sb_if.stall, 1'b0);
    chk1("rst_busy1", sb_if.busy_rs1, 1'b0);
    chk1("rst_busy2", sb_if.busy_rs2, 1'b0);
    chk6("rst_pend", sb_if.pending_count, 6'd0);

    // Release reset, then issue rd=5 with latency 2.
    @(negedge clk);
    rst_n = 1'b1;
    issue(5'd5, 3'd2);
    #1 chk1("rel_issue_stall", sb_if.stall, 1'b0);
    @(negedge clk);                       // cnt5=2
    reader(5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk6("rel_pend1", sb_if.pending_count, 6'd1);
    chk1("rel_stall_c2", sb_if.stall, 1'b1);
    chk1("rel_busy1_c2", sb_if.busy_rs1, 1'b1);
    @(negedge clk);                       // cnt5=1
    #1 chk1("rel_stall_c1", sb_if.stall, 1'b1);
    @(negedge clk);                       // cnt5=0
    #1;
    chk1("rel_stall_c0", sb_if.stall, 1'b0);
    chk6("rel_pend0", sb_if.pending_count, 6'd0);

    // Load-use: latency 1 gives exactly one stall cycle.
    @(negedge clk);
    issue(5'd5, 3'd1);
    #1 chk1("lu_issue_stall", sb_if.stall, 1'b0);
    @(negedge clk);                       // cnt5=1
    reader(5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk1("lu_stall", sb_if.stall, 1'b1);
    chk1("lu_busy1", sb_if.busy_rs1, 1'b1);
    @(negedge clk);                       // cnt5=0
    #1;
    chk1("lu_release", sb_if.stall, 1'b0);
    chk1("lu_busy1_clr", sb_if.busy_rs1, 1'b0);
    chk6("lu_pend", sb_if.pending_count, 6'd0);

    // Long latency: rd=7 latency 4, dependent on rs2, independent rs1=3.
    @(negedge clk);
    issue(5'd7, 3'd4);
    @(negedge clk);                       // cnt7=4
    reader(5'd3, 1'b1, 5'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("ll_stall", sb_if.stall, 1'b1);
      chk1("ll_busy1", sb_if.busy_rs1, 1'b0);
      chk1("ll_busy2", sb_if.busy_rs2, 1'b1);
      @(negedge clk);
    end
    #1;
    chk1("ll_release", sb_if.stall, 1'b0);
    chk1("ll_busy2_clr", sb_if.busy_rs2, 1'b0);
    issue(5'd7, 3'd2);
    @(negedge clk);                       // cnt7=2
    reader(5'd3, 1'b1, 5'd0, 1'b0);
    #1 chk1("ll_indep", sb_if.stall, 1'b0);
    @(negedge clk);                       // cnt7=1
    reader(5'd0, 1'b0, 5'd7, 1'b1);
    #1 chk1("ll_dep_late", sb_if.stall, 1'b1);
    @(negedge clk);                       // cnt7=0
    #1 chk1("ll_dep_late_rel", sb_if.stall, 1'b0);

    // WAW: rd=9 latency 3, then a younger write to rd=9 with latency 1.
    @(negedge clk);
    issue(5'd9, 3'd3);
    @(negedge clk);                       // cnt9=3
    issue(5'd9, 3'd1);
    for (int i = 0; i < 3; i++) begin
      #1 chk1("waw_stall", sb_if.stall, 1'b1);
      @(negedge clk);
    end
    #1 chk1("waw_release", sb_if.stall, 1'b0);
    @(negedge clk);                       // younger write issued: cnt9=1
    reader(5'd9, 1'b1, 5'd0, 1'b0);
    #1;
    chk6("waw_pend", sb_if.pending_count, 6'd1);
    chk1("waw_busy_new", sb_if.busy_rs1, 1'b1);
    @(negedge clk);                       // cnt9=0
    #1;
    chk1("waw_busy_done", sb_if.busy_rs1, 1'b0);
    chk6("waw_pend0", sb_if.pending_count, 6'd0);

    // rs1 == rs2 == busy register; an invalid ID slot never stalls.
    @(negedge clk);
    issue(5'd10, 3'd2);
    @(negedge clk);                       // cnt10=2
    reader(5'd10, 1'b1, 5'd10, 1'b1);
    #1;
    chk1("same_stall", sb_if.stall, 1'b1);
    chk1("same_busy1", sb_if.busy_rs1, 1'b1);
    chk1("same_busy2", sb_if.busy_rs2, 1'b1);
    drive(1'b0, 5'd10, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0);
    #1;
    chk1("inval_stall", sb_if.stall, 1'b0);
    chk1("inval_busy1", sb_if.busy_rs1, 1'b1);
    @(negedge clk);                       // cnt10=1
    reader(5'd10, 1'b1, 5'd10, 1'b1);
    #1 chk1("same_stall_c1", sb_if.stall, 1'b1);
    @(negedge clk);                       // cnt10=0
    #1 chk1("same_release", sb_if.stall, 1'b0);

    // Flush: registers 2, 4 and 6 active, and an issue in the same cycle as the flush.
    @(negedge clk);
    issue(5'd2, 3'd7);
    @(negedge clk);
    issue(5'd4, 3'd7);
    @(negedge clk);
    issue(5'd6, 3'd7);
    @(negedge clk);                       // cnt2=5 cnt4=6 cnt6=7
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 3'd3, 1'b1);
    #1;
    chk6("fl_pend3", sb_if.pending_count, 6'd3);
    chk1("fl_stall", sb_if.stall, 1'b0);
    @(negedge clk);
    reader(5'd4, 1'b1, 5'd11, 1'b1);
    #1;
    chk6("fl_pend0", sb_if.pending_count, 6'd0);
    chk1("fl_after_stall", sb_if.stall, 1'b0);
    chk1("fl_after_busy1", sb_if.busy_rs1, 1'b0);
    chk1("fl_no_issue_rd11", sb_if.busy_rs2, 1'b0);

    // Zero register and latency-0 writes never mark a register.
    @(negedge clk);
    issue(5'd0, 3'd5);
    @(negedge clk);
    issue(5'd8, 3'd0);
    #1 chk6("z_pend_rd0", sb_if.pending_count, 6'd0);
    @(negedge clk);
    reader(5'd0, 1'b1, 5'd8, 1'b1);
    #1;
    chk6("z_pend_rd8", sb_if.pending_count, 6'd0);
    chk1("z_stall", sb_if.stall, 1'b0);
    chk1("z_busy1", sb_if.busy_rs1, 1'b0);
    chk1("z_busy2", sb_if.busy_rs2, 1'b0);

    // Reset asserted in the middle of a countdown clears state immediately.
    @(negedge clk);
    issue(5'd12, 3'd7);
    @(negedge clk);                       // cnt12=7
    reader(5'd12, 1'b1, 5'd0, 1'b0);
    #1;
    chk1("mr_busy_before", sb_if.busy_rs1, 1'b1);
    chk6("mr_pend_before", sb_if.pending_count, 6'd1);
    #2 rst_n = 1'b0;
    #1;
    chk1("mr_busy_async", sb_if.busy_rs1, 1'b0);
    chk1("mr_stall_async", sb_if.stall, 1'b0);
    chk6("mr_pend_async", sb_if.pending_count, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk1("mr_stall_rel", sb_if.stall, 1'b0);
    @(negedge clk);
    #1;
    chk1("mr_busy_rel", sb_if.busy_rs1, 1'b0);
    chk6("mr_pend_rel", sb_if.pending_count, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
